// File: rtl/urng_taus_src.sv
// urng_taus_src: two taus88 generators with runtime seed shadow, warm-up and a valid/ready sample register.
// Optional build macro URNG_SAMPLE_CNT_EN adds the sample_cnt handshake counter output.
module urng_taus_src #(
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter logic [95:0] SEED_A        = 96'h0000_3039_0000_D431_0001_E240,
  parameter logic [95:0] SEED_B        = 96'h1234_5678_89AB_CDEF_0F1E_2D3C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        seed_we,
  input  logic [2:0]  seed_addr,
  input  logic [31:0] seed_data,
  input  logic        seed_load,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [47:0] u0,
  output logic [15:0] u1,
  output logic        busy
`ifdef URNG_SAMPLE_CNT_EN
  ,
  output logic [31:0] sample_cnt
`endif
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATE_W = 96;

  typedef enum logic {ST_WARM, ST_RUN} state_e;

  // One taus88 step of a {s1,s2,s3} state vector.
  function automatic logic [STATE_W-1:0] taus_step(input logic [STATE_W-1:0] s);
    logic [31:0] s1, s2, s3, b;
    s1 = s[95:64];
    s2 = s[63:32];
    s3 = s[31:0];
    b  = ((s1 << 13) ^ s1) >> 19;
    s1 = ((s1 & 32'hFFFF_FFFE) << 12) ^ b;
    b  = ((s2 << 2) ^ s2) >> 25;
    s2 = ((s2 & 32'hFFFF_FFF8) << 4) ^ b;
    b  = ((s3 << 3) ^ s3) >> 11;
    s3 = ((s3 & 32'hFFFF_FFF0) << 17) ^ b;
    return {s1, s2, s3};
  endfunction

  function automatic logic [31:0] taus_out(input logic [STATE_W-1:0] s);
    return s[95:64] ^ s[63:32] ^ s[31:0];
  endfunction

  // Words below the generator's minimum would lock it up; fall back to the reset seed word.
  function automatic logic [STATE_W-1:0] legalise(input logic [STATE_W-1:0] sh,
                                                  input logic [STATE_W-1:0] dflt);
    logic [STATE_W-1:0] r;
    r = sh;
    if (sh[95:64] < 32'd2)  r[95:64] = dflt[95:64];
    if (sh[63:32] < 32'd8)  r[63:32] = dflt[63:32];
    if (sh[31:0]  < 32'd16) r[31:0]  = dflt[31:0];
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] gen_a_q, gen_a_d, gen_b_q, gen_b_d;
  logic [STATE_W-1:0] shadow_a_q, shadow_a_d, shadow_b_q, shadow_b_d;
  logic               valid_q, valid_d;
  logic [47:0]        u0_q, u0_d;
  logic [15:0]        u1_q, u1_d;
  logic               busy_q, busy_d;
  logic [STATE_W-1:0] step_a, step_b;
  logic [31:0]        t_a, t_b;
  logic               handshake;

  assign step_a    = taus_step(gen_a_q);
  assign step_b    = taus_step(gen_b_q);
  assign t_a       = taus_out(step_a);
  assign t_b       = taus_out(step_b);
  assign handshake = valid_q & out_ready;

  // Next-state: shadow write, FSM step/handshake, then seed_load overrides everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gen_a_d    = gen_a_q;
    gen_b_d    = gen_b_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    valid_d    = valid_q;
    u0_d       = u0_q;
    u1_d       = u1_q;

    if (seed_we) begin
      case (seed_addr)
        3'd0:    shadow_a_d[95:64] = seed_data;
        3'd1:    shadow_a_d[63:32] = seed_data;
        3'd2:    shadow_a_d[31:0]  = seed_data;
        3'd3:    shadow_b_d[95:64] = seed_data;
        3'd4:    shadow_b_d[63:32] = seed_data;
        3'd5:    shadow_b_d[31:0]  = seed_data;
        default: ;
      endcase
    end

    case (state_q)
      ST_WARM: begin
        valid_d = 1'b0;
        if (en) begin
          gen_a_d = step_a;
          gen_b_d = step_b;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(WARMUP_CYCLES)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (en && (!valid_q || out_ready)) begin
          gen_a_d = step_a;
          gen_b_d = step_b;
          valid_d = 1'b1;
          u0_d    = {t_a, t_b[31:16]};
          u1_d    = t_b[15:0];
        end else if (handshake) begin
          valid_d = 1'b0;
        end
      end
    endcase

    if (seed_load) begin
      gen_a_d = legalise(shadow_a_d, SEED_A);
      gen_b_d = legalise(shadow_b_d, SEED_B);
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = ST_WARM;
    end

    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_WARM;
      cnt_q      <= '0;
      gen_a_q    <= SEED_A;
      gen_b_q    <= SEED_B;
      shadow_a_q <= SEED_A;
      shadow_b_q <= SEED_B;
      valid_q    <= 1'b0;
      u0_q       <= '0;
      u1_q       <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gen_a_q    <= gen_a_d;
      gen_b_q    <= gen_b_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      valid_q    <= valid_d;
      u0_q       <= u0_d;
      u1_q       <= u1_d;
      busy_q     <= busy_d;
    end
  end

  assign out_valid = valid_q;
  assign u0        = u0_q;
  assign u1        = u1_q;
  assign busy      = busy_q;

`ifdef URNG_SAMPLE_CNT_EN
  logic [31:0] sample_cnt_q, sample_cnt_d;

  // Completed handshakes since reset or the last seed_load; wraps naturally.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    if (handshake) sample_cnt_d = sample_cnt_q + 32'd1;
    if (seed_load) sample_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sample_cnt_q <= '0;
    else        sample_cnt_q <= sample_cnt_d;
  end

  assign sample_cnt = sample_cnt_q;
`endif

endmodule

// File: tb/tb_urng_taus_src.sv
// Self-checking bench for urng_taus_src against a transaction-level taus88 reference model.
module tb_urng_taus_src;

  localparam int          WARMUP = 16;
  localparam logic [95:0] SEED_A = 96'h0000_3039_0000_D431_0001_E240;
  localparam logic [95:0] SEED_B = 96'h1234_5678_89AB_CDEF_0F1E_2D3C;

  logic        clk = 1'b0;
  logic        reset, en, seed_we, seed_load, out_ready;
  logic [2:0]  seed_addr;
  logic [31:0] seed_data;
  logic        out_valid, busy;
  logic [47:0] u0;
  logic [15:0] u1;
`ifdef URNG_SAMPLE_CNT_EN
  logic [31:0] sample_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // m[g][j]: generator g (0=A, 1=B), word j (s1..s3)
  logic [31:0] m [2][3];

  always #5 clk = ~clk;

  urng_taus_src #(.WARMUP_CYCLES(WARMUP), .SEED_A(SEED_A), .SEED_B(SEED_B)) dut (
    .clk(clk), .reset(reset), .en(en), .seed_we(seed_we), .seed_addr(seed_addr),
    .seed_data(seed_data), .seed_load(seed_load), .out_ready(out_ready),
    .out_valid(out_valid), .u0(u0), .u1(u1), .busy(busy)
`ifdef URNG_SAMPLE_CNT_EN
    , .sample_cnt(sample_cnt)
`endif
  );

  function automatic logic [31:0] tw(input logic [31:0] s, input int j);
    int unsigned q, r, k;
    logic [31:0] msk;
    case (j)
      0:       begin q = 13; r = 19; k = 12; msk = 32'hFFFF_FFFE; end
      1:       begin q = 2;  r = 25; k = 4;  msk = 32'hFFFF_FFF8; end
      default: begin q = 3;  r = 11; k = 17; msk = 32'hFFFF_FFF0; end
    endcase
    return (((s << q) ^ s) >> r) ^ ((s & msk) << k);
  endfunction

  task automatic model_advance(output logic [31:0] ta, output logic [31:0] tb);
    logic [31:0] t [2];
    for (int g = 0; g < 2; g++) begin
      t[g] = '0;
      for (int j = 0; j < 3; j++) begin
        m[g][j] = tw(m[g][j], j);
        t[g] ^= m[g][j];
      end
    end
    ta = t[0];
    tb = t[1];
  endtask

  task automatic model_next(output logic [47:0] e0, output logic [15:0] e1);
    logic [31:0] ta, tb;
    model_advance(ta, tb);
    e0 = {ta, tb[31:16]};
    e1 = tb[15:0];
  endtask

  // Load raw shadow words, apply the minimum-word rule, discard the warm-up steps.
  task automatic model_seed(input logic [95:0] a, input logic [95:0] b);
    logic [31:0] mins [3];
    logic [31:0] ta, tb;
    logic [95:0] raw [2];
    logic [95:0] dflt [2];
    mins[0] = 2; mins[1] = 8; mins[2] = 16;
    raw[0] = a; raw[1] = b; dflt[0] = SEED_A; dflt[1] = SEED_B;
    for (int g = 0; g < 2; g++)
      for (int j = 0; j < 3; j++) begin
        m[g][j] = raw[g][95-32*j -: 32];
        if (m[g][j] < mins[j]) m[g][j] = dflt[g][95-32*j -: 32];
      end
    for (int i = 0; i < WARMUP; i++) model_advance(ta, tb);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; en = 1'b0; seed_we = 1'b0; seed_load = 1'b0; out_ready = 1'b0;
    seed_addr = '0; seed_data = '0;
    tick; tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (u0 !== 48'd0) begin errors++; $display("FAIL reset_u0: got %h want 0", u0); end
    checks++; if (u1 !== 16'd0) begin errors++; $display("FAIL reset_u1: got %h want 0", u1); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
  endtask

  task automatic test_first_valid;
    logic [47:0] e0; logic [15:0] e1;
    en = 1'b1; out_ready = 1'b1; reset = 1'b1;
    model_seed(SEED_A, SEED_B);
    for (int n = 1; n <= WARMUP + 1; n++) begin
      tick;
      if (n == WARMUP - 1) begin checks++; if (busy !== 1'b1) begin errors++; $display("FAIL warm_busy: got %b want 1", busy); end end
      if (n == WARMUP) begin checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_busy: got %b want 0", busy); end end
      checks++;
      if (out_valid !== (n == WARMUP + 1)) begin
        errors++; $display("FAIL first_valid cycle %0d: got %b want %b", n, out_valid, (n == WARMUP + 1));
      end
    end
    for (int i = 0; i < 1000; i++) begin
      model_next(e0, e1);
      checks++;
      if (out_valid !== 1'b1 || u0 !== e0 || u1 !== e1) begin
        errors++; $display("FAIL stream sample %0d: got v=%b %h/%h want v=1 %h/%h", i, out_valid, u0, u1, e0, e1);
      end
      tick;
    end
  endtask

  task automatic test_stall;
    logic [47:0] e0, h0; logic [15:0] e1, h1;
    out_ready = 1'b0; h0 = u0; h1 = u1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || u0 !== h0 || u1 !== h1) begin
        errors++; $display("FAIL stall hold %0d: got v=%b %h/%h want v=1 %h/%h", i, out_valid, u0, u1, h0, h1);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      model_next(e0, e1);
      checks++;
      if (out_valid !== 1'b1 || u0 !== e0 || u1 !== e1) begin
        errors++; $display("FAIL stall resume %0d: got v=%b %h/%h want v=1 %h/%h", i, out_valid, u0, u1, e0, e1);
      end
      tick;
    end
  endtask

  task automatic test_random;
    logic [47:0] e0, p0; logic [15:0] e1, p1;
    logic pv, pr, pe, want_v;
    int acc = 0;
    for (int i = 0; i < 500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      pv = out_valid; pr = out_ready; pe = en; p0 = u0; p1 = u1;
      if (out_valid && out_ready) begin
        acc++;
        model_next(e0, e1);
        checks++;
        if (u0 !== e0 || u1 !== e1) begin
          errors++; $display("FAIL random sample %0d: got %h/%h want %h/%h", i, u0, u1, e0, e1);
        end
      end
      tick;
      want_v = (pv && !pr) || pe;
      checks++;
      if (out_valid !== want_v) begin
        errors++; $display("FAIL random valid %0d: got %b want %b", i, out_valid, want_v);
      end
      if (pv && !pr) begin
        checks++;
        if (u0 !== p0 || u1 !== p1) begin
          errors++; $display("FAIL random hold %0d: got %h/%h want %h/%h", i, u0, u1, p0, p1);
        end
      end
    end
    checks++;
    if (acc < 100) begin errors++; $display("FAIL random throughput: got %0d want >=100", acc); end
    en = 1'b1; out_ready = 1'b1;
  endtask

  task automatic test_reseed;
    logic [47:0] e0, h0; logic [15:0] e1, h1; logic hv;
    en = 1'b0; out_ready = 1'b0; hv = out_valid; h0 = u0; h1 = u1;
    seed_we = 1'b1; seed_addr = 3'd0; seed_data = 32'd0; tick;
    seed_addr = 3'd1; seed_data = 32'd5; tick;
    checks++;
    if (out_valid !== hv || u0 !== h0 || u1 !== h1) begin
      errors++; $display("FAIL shadow write disturbed output: got v=%b %h/%h want v=%b %h/%h", out_valid, u0, u1, hv, h0, h1);
    end
    seed_addr = 3'd5; seed_data = 32'hFFFF_FFFF; seed_load = 1'b1; tick;
    seed_we = 1'b0; seed_load = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reseed valid drop: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reseed busy: got %b want 1", busy); end
    model_seed({32'd0, 32'd5, SEED_A[31:0]}, {SEED_B[95:32], 32'hFFFF_FFFF});
    en = 1'b1; out_ready = 1'b1;
    for (int n = 1; n <= WARMUP + 1; n++) begin
      tick;
      checks++;
      if (out_valid !== (n == WARMUP + 1)) begin
        errors++; $display("FAIL reseed latency cycle %0d: got %b want %b", n, out_valid, (n == WARMUP + 1));
      end
    end
    for (int i = 0; i < 50; i++) begin
      model_next(e0, e1);
      checks++;
      if (out_valid !== 1'b1 || u0 !== e0 || u1 !== e1) begin
        errors++; $display("FAIL reseed sample %0d: got v=%b %h/%h want v=1 %h/%h", i, out_valid, u0, u1, e0, e1);
      end
      tick;
    end
  endtask

  task automatic test_reseed_handshake;
    logic [47:0] e0; logic [15:0] e1;
    model_next(e0, e1);
    checks++;
    if (out_valid !== 1'b1 || u0 !== e0 || u1 !== e1) begin
      errors++; $display("FAIL load handshake sample: got v=%b %h/%h want v=1 %h/%h", out_valid, u0, u1, e0, e1);
    end
    seed_load = 1'b1; tick; seed_load = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load handshake valid: got %b want 0", out_valid); end
`ifdef URNG_SAMPLE_CNT_EN
    checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL load handshake cnt: got %h want 0", sample_cnt); end
`endif
    model_seed({32'd0, 32'd5, SEED_A[31:0]}, {SEED_B[95:32], 32'hFFFF_FFFF});
    for (int n = 1; n <= WARMUP + 1; n++) begin
      tick;
      checks++;
      if (out_valid !== (n == WARMUP + 1)) begin
        errors++; $display("FAIL load handshake latency %0d: got %b want %b", n, out_valid, (n == WARMUP + 1));
      end
    end
    for (int i = 0; i < 30; i++) begin
      model_next(e0, e1);
      checks++;
      if (out_valid !== 1'b1 || u0 !== e0 || u1 !== e1) begin
        errors++; $display("FAIL load handshake stream %0d: got v=%b %h/%h want v=1 %h/%h", i, out_valid, u0, u1, e0, e1);
      end
      tick;
    end
  endtask

  task automatic test_en_toggle;
    logic [47:0] e0, h0; logic [15:0] e1, h1;
    model_next(e0, e1);
    seed_load = 1'b1; tick; seed_load = 1'b0;
    model_seed({32'd0, 32'd5, SEED_A[31:0]}, {SEED_B[95:32], 32'hFFFF_FFFF});
    for (int n = 1; n <= WARMUP + 4; n++) begin
      en = (n <= 5 || n > 8);
      tick;
      checks++;
      if (out_valid !== (n == WARMUP + 4)) begin
        errors++; $display("FAIL en warm cycle %0d: got %b want %b", n, out_valid, (n == WARMUP + 4));
      end
    end
    model_next(e0, e1);
    checks++;
    if (u0 !== e0 || u1 !== e1) begin
      errors++; $display("FAIL en first sample: got %h/%h want %h/%h", u0, u1, e0, e1);
    end
    h0 = u0; h1 = u1;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0 || u0 !== h0 || u1 !== h1) begin
        errors++; $display("FAIL en run freeze %0d: got v=%b %h/%h want v=0 %h/%h", i, out_valid, u0, u1, h0, h1);
      end
    end
    en = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      model_next(e0, e1);
      checks++;
      if (out_valid !== 1'b1 || u0 !== e0 || u1 !== e1) begin
        errors++; $display("FAIL en resume %0d: got v=%b %h/%h want v=1 %h/%h", i, out_valid, u0, u1, e0, e1);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    logic [47:0] e0; logic [15:0] e1;
    reset = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || u0 !== 48'd0 || u1 !== 16'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL async reset: got v=%b %h/%h busy=%b want v=0 0/0 busy=1", out_valid, u0, u1, busy);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_seed(SEED_A, SEED_B);
    for (int pass = 0; pass < 2; pass++) begin
      for (int n = 1; n <= WARMUP + 1; n++) begin
        tick;
        checks++;
        if (out_valid !== (n == WARMUP + 1)) begin
          errors++; $display("FAIL reset restart p%0d cycle %0d: got %b want %b", pass, n, out_valid, (n == WARMUP + 1));
        end
      end
      for (int i = 0; i < 20; i++) begin
        model_next(e0, e1);
        checks++;
        if (out_valid !== 1'b1 || u0 !== e0 || u1 !== e1) begin
          errors++; $display("FAIL reset restart p%0d sample %0d: got v=%b %h/%h want v=1 %h/%h", pass, i, out_valid, u0, u1, e0, e1);
        end
        tick;
      end
      if (pass == 0) begin
        // the shadow must also have returned to the reset seeds
        model_next(e0, e1);
        seed_load = 1'b1; tick; seed_load = 1'b0;
        model_seed(SEED_A, SEED_B);
        for (int n = 1; n < WARMUP + 1; n++) tick;
        tick;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL shadow reset latency: got %b want 1", out_valid); end
        model_next(e0, e1);
        checks++;
        if (u0 !== e0 || u1 !== e1) begin
          errors++; $display("FAIL shadow reset sample: got %h/%h want %h/%h", u0, u1, e0, e1);
        end
        break;
      end
    end
  endtask

`ifdef URNG_SAMPLE_CNT_EN
  task automatic test_sample_cnt;
    logic [31:0] want;
    out_ready = 1'b0;
    force dut.sample_cnt_q = 32'hFFFF_FFFE;
    tick;
    release dut.sample_cnt_q;
    out_ready = 1'b1;
    want = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      tick;
      want = want + 32'd1;
      checks++;
      if (sample_cnt !== want) begin errors++; $display("FAIL sample_cnt wrap %0d: got %h want %h", i, sample_cnt, want); end
    end
    out_ready = 1'b0; seed_load = 1'b1; tick; seed_load = 1'b0;
    checks++;
    if (sample_cnt !== 32'd0) begin errors++; $display("FAIL sample_cnt load clear: got %h want 0", sample_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_first_valid;
    test_stall;
    test_random;
    test_reseed;
    test_reseed_handshake;
    test_en_toggle;
    test_reset_mid;
`ifdef URNG_SAMPLE_CNT_EN
    test_sample_cnt;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
